// File: rtl/rob_commit_seq.sv
// Commit sequencer behind the reorder buffer: throttles in-order commit, frees old
// physical mappings, hands stores to the LSU and sequences mispredict recovery.
module rob_commit_seq #(
  parameter int PHYS_W       = 7,
  parameter int IDX_W        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_valid_i,
  input  logic [IDX_W-1:0]  commit_idx_i,
  input  logic [PHYS_W-1:0] commit_rd_phys_i,
  input  logic [PHYS_W-1:0] commit_old_phys_i,
  input  logic              commit_is_store_i,
  input  logic              commit_branch_misp_i,
  input  logic [63:0]       commit_branch_target_i,
  output logic              commit_ready_o,
  output logic              free_valid_o,
  output logic [PHYS_W-1:0] free_phys_o,
  output logic              st_commit_valid_o,
  output logic [IDX_W-1:0]  st_commit_idx_o,
  input  logic              st_commit_ready_i,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [63:0]       redirect_pc_o,
  input  logic              redirect_ready_i,
  output logic [63:0]       commit_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic              proto_err_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    ST_WAIT  = 3'd1,
    FLUSH    = 3'd2,
    REDIRECT = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t            state, next_state;
  logic              commit_acc;
  logic [IDX_W-1:0]  st_idx_p1;
  logic              misp_p1;
  logic [63:0]       target_p1;
  logic [7:0]        drain_cnt;

  // The destination mapping stays live in the rename table; only the old one is freed.
  logic unused_rd;
  assign unused_rd = ^commit_rd_phys_i;

  assign commit_acc     = commit_valid_i && (state == RUN);
  assign commit_ready_o = (state == RUN) &&
                          !(commit_valid_i && (commit_is_store_i || commit_branch_misp_i));

  assign st_commit_valid_o = (state == ST_WAIT);
  assign st_commit_idx_o   = st_idx_p1;
  assign flush_o           = (state == FLUSH);
  assign redirect_valid_o  = (state == FLUSH) || (state == REDIRECT);
  assign redirect_pc_o     = target_p1;

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (commit_acc) begin
          if (commit_is_store_i)         next_state = ST_WAIT;
          else if (commit_branch_misp_i) next_state = FLUSH;
        end
      end
      ST_WAIT:  if (st_commit_ready_i) next_state = misp_p1 ? FLUSH : RUN;
      FLUSH:    next_state = redirect_ready_i ? DRAIN : REDIRECT;
      REDIRECT: if (redirect_ready_i) next_state = DRAIN;
      DRAIN:    if (drain_cnt == 8'd1) next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Commit-stage captures: free pulse, store/branch latches and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid_o <= 1'b0;
      free_phys_o  <= '0;
      st_idx_p1    <= '0;
      misp_p1      <= 1'b0;
      target_p1    <= '0;
      drain_cnt    <= '0;
      commit_cnt_o <= '0;
      flush_cnt_o  <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      free_valid_o <= commit_acc && (commit_old_phys_i != '0);
      if (commit_acc && (commit_old_phys_i != '0)) free_phys_o <= commit_old_phys_i;
      if (commit_acc) commit_cnt_o <= commit_cnt_o + 64'd1;
      if (commit_acc && commit_is_store_i) begin
        st_idx_p1 <= commit_idx_i;
        misp_p1   <= commit_branch_misp_i;
      end
      if (commit_acc && (commit_is_store_i || commit_branch_misp_i))
        target_p1 <= commit_branch_target_i;
      if (state == FLUSH) flush_cnt_o <= flush_cnt_o + 32'd1;
      if (next_state == DRAIN && state != DRAIN) drain_cnt <= 8'(DRAIN_CYCLES);
      else if (state == DRAIN)                   drain_cnt <= drain_cnt - 8'd1;
      if (commit_valid_i && state != RUN) proto_err_o <= 1'b1;
    end
  end

endmodule
